// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 6-digit common-anode 7-seg scan controller, double-buffered display data
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 0..4.
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [23:0] disp_data,
  input  logic [5:0]  dp_en,
  input  logic [5:0]  digit_mask,
  output logic [2:0]  bit_disp,
  output logic [7:0]  seg_led,
  output logic        frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

  logic [PW-1:0] presc;
  logic [2:0]    digit;
  logic [23:0]   act_data, pend_data;
  logic [5:0]    act_dp, act_mask, pend_dp, pend_mask;
  logic          pend_valid;

  logic          slot_end, wrap;
  logic [3:0]    nib;
  logic          dp_on, shown, lz_blank;
  logic [7:0]    seg_next;

  assign slot_end = (presc == PRESC_MAX);
  assign wrap     = slot_end && (digit == 3'd5);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    nib   = 4'h0;
    dp_on = 1'b0;
    shown = 1'b0;
    case (digit)
      3'd0: begin nib = act_data[23:20]; dp_on = act_dp[0]; shown = act_mask[0]; end
      3'd1: begin nib = act_data[19:16]; dp_on = act_dp[1]; shown = act_mask[1]; end
      3'd2: begin nib = act_data[15:12]; dp_on = act_dp[2]; shown = act_mask[2]; end
      3'd3: begin nib = act_data[11:8];  dp_on = act_dp[3]; shown = act_mask[3]; end
      3'd4: begin nib = act_data[7:4];   dp_on = act_dp[4]; shown = act_mask[4]; end
      3'd5: begin nib = act_data[3:0];   dp_on = act_dp[5]; shown = act_mask[5]; end
      default: ;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i] = every nibble from digit 0 through digit i is zero; digit 5 never qualifies.
  logic [7:0] lead_zero;
  logic       lz_run;
  always_comb begin
    lead_zero = 8'h00;
    lz_run    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lz_run       = lz_run && (act_data[23-4*i -: 4] == 4'h0);
      lead_zero[i] = lz_run;
    end
  end
  assign lz_blank = lead_zero[digit];
`else
  assign lz_blank = 1'b0;
`endif

  assign seg_next = !shown ? 8'hFF : {~dp_on, (lz_blank ? 7'h7F : hex_to_seg(nib))};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      digit      <= 3'd0;
      act_data   <= 24'h0;
      act_dp     <= 6'h0;
      act_mask   <= 6'h0;
      pend_data  <= 24'h0;
      pend_dp    <= 6'h0;
      pend_mask  <= 6'h0;
      pend_valid <= 1'b0;
      bit_disp   <= 3'b111;
      seg_led    <= 8'hFF;
      frame_done <= 1'b0;
    end else if (!en) begin
      presc      <= '0;
      digit      <= 3'd0;
      bit_disp   <= 3'b111;
      seg_led    <= 8'hFF;
      frame_done <= 1'b0;
      // Nothing is being scanned, so there is no frame to tear: write straight through.
      if (load) begin
        act_data   <= disp_data;
        act_dp     <= dp_en;
        act_mask   <= digit_mask;
        pend_valid <= 1'b0;
      end
    end else begin
      bit_disp   <= digit;
      seg_led    <= (presc < BLANK_END) ? 8'hFF : seg_next;
      frame_done <= wrap;

      if (slot_end) begin
        presc <= '0;
        digit <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      if (wrap && load) begin
        act_data   <= disp_data;
        act_dp     <= dp_en;
        act_mask   <= digit_mask;
        pend_valid <= 1'b0;
      end else begin
        if (wrap && pend_valid) begin
          act_data   <= pend_data;
          act_dp     <= pend_dp;
          act_mask   <= pend_mask;
          pend_valid <= 1'b0;
        end
        if (load) begin
          pend_data  <= disp_data;
          pend_dp    <= dp_en;
          pend_mask  <= digit_mask;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule
